uart_tx_sched: RTL
==================

# uart_tx_sched

Two-channel scheduler that shares the single UART transmitter between the ALU result path (16-bit, sent as two frames) and the register-file read path (8-bit, one frame). It sits in the UART clock domain between the requesters and the UART TX front end. It drives the transmitter's parallel data and data-valid inputs and tracks the transmitter's busy output so that one frame completes before the next is issued. Arbitration is round-robin when both channels are pending.

## Interface
- `DATA_WIDTH`, default 8: UART frame payload width; the ALU channel carries 2×`DATA_WIDTH`.
- `CLK` input 1: single clock, all logic on rising edge.
- `RST` input 1: synchronous, active-low reset.
- `ALU_VLD` input 1: ALU channel request valid.
- `ALU_DATA` input 2×`DATA_WIDTH`: ALU result; low byte is sent first, then high byte.
- `ALU_RDY` output 1: ALU channel accept; a transfer occurs when `ALU_VLD` and `ALU_RDY` are both high.
- `RF_VLD` input 1: register-file channel request valid.
- `RF_DATA` input `DATA_WIDTH`: register-file read data.
- `RF_RDY` output 1: register-file channel accept.
- `TX_BUSY` input 1: busy output of the UART transmitter.
- `TX_P_DATA` output `DATA_WIDTH`: parallel data to the transmitter.
- `TX_D_VLD` output 1: single-cycle load strobe to the transmitter.
- `SCHED_BUSY` output 1: high whenever the scheduler is not in IDLE.

## Operation
- **States:** IDLE, LOAD, WAIT_HI, WAIT_LO.
- **Registers:**
  - `hold` holds 2×`DATA_WIDTH` of payload.
  - `src` is 1 bit: 0 = ALU, 1 = RF.
  - `byte_idx` is 1 bit.
  - `last_grant` is 1 bit; reset value 1, so ALU wins the first tie.
- **IDLE:**
  - Grant selection, combinational, only when `TX_BUSY`=0:
    - Only one VLD high: grant that channel.
    - Both high: grant the channel opposite `last_grant`.
  - `ALU_RDY`/`RF_RDY` are high only for the granted channel, only in IDLE, and only when `TX_BUSY`=0.
  - On transfer:
    - Capture the data into `hold`. RF data goes in the low byte and the high byte is zeroed.
    - Set `src`, clear `byte_idx`, and update `last_grant`.
    - Next state is LOAD.
- **LOAD:**
  - `TX_D_VLD`=1 for exactly this one cycle.
  - `TX_P_DATA` = `hold[byte_idx]`.
  - Next state is WAIT_HI unconditionally.
- **WAIT_HI:** stay until `TX_BUSY`=1, then go to WAIT_LO.
- **WAIT_LO:** stay until `TX_BUSY`=0, then:
  - If `src`=ALU and `byte_idx`=0: set `byte_idx`=1 and go to LOAD.
  - Otherwise go to IDLE.
- **`TX_P_DATA` stability:** it is driven from `hold`/`byte_idx` and held stable from LOAD until the next capture. The transmitter latches it at the LOAD cycle.
- **Requests arriving outside IDLE:** they are not accepted. The requester holds VLD and DATA stable until its RDY is seen; no request is dropped.
- **Unused/illegal state encoding:** next state is IDLE and outputs take their idle values.
- **Reset:** synchronous reset has precedence over every transition, including mid-frame.
  - State goes to IDLE, `last_grant` to 1, `hold` to 0, `byte_idx` to 0.
  - Any partially sent ALU pair is abandoned.

## Timing
- **Reset values:**
  - `TX_D_VLD`=0.
  - `TX_P_DATA`=0.
  - `SCHED_BUSY`=0.
  - `ALU_RDY`/`RF_RDY` follow the IDLE rule.
- **Issue latency:** with the transfer at cycle T, `TX_D_VLD` is high at T+1.
- **Transmitter response:** busy rises at T+2, one cycle after load. It stays high for the frame length F: 10 cycles without parity, 11 with parity.
- **Return to IDLE (RF, single frame):** the first cycle with `TX_BUSY`=0 is T+2+F; the scheduler is in IDLE at T+3+F. The next transfer is possible in that cycle if `TX_BUSY`=0.
- **ALU pair:**
  - Second `TX_D_VLD` at T+3+F.
  - IDLE at T+5+2F.
- **Unbounded busy:** if `TX_BUSY` never rises, the FSM remains in WAIT_HI with no timeout. This is a defined behaviour and the bench checks it.
- **`SCHED_BUSY`:** high from T+1 until the cycle before IDLE is re-entered.

## Test plan
- Reset with `RST`=0 for 3 cycles while `ALU_VLD`=1 -> `TX_D_VLD`=0, `TX_P_DATA`=0x00, `SCHED_BUSY`=0, no RDY during reset; after release `ALU_RDY`=1 in the first cycle.
- RF only:
  - Stimulus: `RF_DATA`=0xA5; transmitter model busy for 10 cycles starting 1 cycle after load.
  - Response: one `TX_D_VLD` pulse with `TX_P_DATA`=0xA5 at T+1; IDLE at T+13.
- ALU only:
  - Stimulus: `ALU_DATA`=0x3C7E.
  - Response: `TX_D_VLD` pulses with 0x7E then 0x3C, 12 cycles apart (F=10); IDLE at T+25.
- Both VLD high continuously, starting after reset:
  - Grant order is ALU, RF, ALU, RF.
  - No `TX_D_VLD` while `TX_BUSY`=1.
  - Each RDY pulses exactly once per served request.
- `RF_VLD` raised during an ALU pair -> `RF_RDY` stays 0 until IDLE; served next with data unchanged.
- Reset asserted in WAIT_LO between the ALU bytes -> no second pulse; IDLE after reset; `last_grant`=1, so the next tie grants ALU.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester, transmitter and status signals of the UART TX scheduler
interface uart_tx_sched_if #(parameter int DATA_WIDTH = 8);
  logic                    alu_vld;
  logic [2*DATA_WIDTH-1:0] alu_data;
  logic                    alu_rdy;
  logic                    rf_vld;
  logic [DATA_WIDTH-1:0]   rf_data;
  logic                    rf_rdy;
  logic                    tx_busy;
  logic [DATA_WIDTH-1:0]   tx_p_data;
  logic                    tx_d_vld;
  logic                    sched_busy;
  modport master (
    input  alu_vld, alu_data, rf_vld, rf_data, tx_busy,
    output alu_rdy, rf_rdy, tx_p_data, tx_d_vld, sched_busy
  );
  modport slave (
    output alu_vld, alu_data, rf_vld, rf_data, tx_busy,
    input  alu_rdy, rf_rdy, tx_p_data, tx_d_vld, sched_busy
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin scheduler sharing one UART transmitter between the ALU and register-file channels
module uart_tx_sched #(parameter int DATA_WIDTH = 8) (
  input logic clk,
  input logic rst,
  uart_tx_sched_if.master bus
);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;
  state_t                  state, state_nx;
  logic [2*DATA_WIDTH-1:0] hold;
  logic                    src, byte_idx, last_grant;
  logic                    accept_ok, pick_rf, xfer;
  always_comb begin
    accept_ok      = state == IDLE && !bus.tx_busy && rst;
    pick_rf        = (bus.alu_vld && bus.rf_vld) ? !last_grant : bus.rf_vld;
    bus.alu_rdy    = accept_ok && bus.alu_vld && !pick_rf;
    bus.rf_rdy     = accept_ok && bus.rf_vld && pick_rf;
    xfer           = bus.alu_rdy || bus.rf_rdy;
    bus.tx_d_vld   = state == LOAD;
    bus.sched_busy = state != IDLE;
    bus.tx_p_data  = byte_idx ? hold[DATA_WIDTH +: DATA_WIDTH] : hold[0 +: DATA_WIDTH];
    state_nx       = IDLE;
    case (state)
      IDLE:    state_nx = xfer ? LOAD : IDLE;
      LOAD:    state_nx = WAIT_HI;
      WAIT_HI: state_nx = bus.tx_busy ? WAIT_LO : WAIT_HI;
      WAIT_LO: state_nx = bus.tx_busy ? WAIT_LO : (!src && !byte_idx) ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      hold       <= '0;
      src        <= 1'b0;
      byte_idx   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      if (xfer) begin
        hold       <= bus.rf_rdy ? {{DATA_WIDTH{1'b0}}, bus.rf_data} : bus.alu_data;
        src        <= bus.rf_rdy;
        byte_idx   <= 1'b0;
        last_grant <= bus.rf_rdy;
      end else if (state == WAIT_LO && !bus.tx_busy && !src) begin
        byte_idx <= 1'b1;
      end
    end
  end
endmodule
